// File: rtl/huffman_pkg.sv
// Shared constants, FSM state type and mask popcount helper for the Huffman packer.
package huffman_pkg;

    localparam int NSYM   = 6;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    // Code length is the number of set bits in a mask; callers zero-extend the mask.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/huffman_code_lut.sv
// Six-entry {code, length} table loaded on code_valid, plus the symbol lookup.
module huffman_code_lut
    import huffman_pkg::*;
#(
    parameter  int CODE_W = 8,
    localparam int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] hc   [NSYM],
    input  logic [CODE_W-1:0] mask [NSYM],
    input  logic [7:0]        sym,
    output logic [CODE_W-1:0] code,
    output logic [LEN_W-1:0]  len,
    output logic              illegal
);

    logic [CODE_W-1:0] code_tbl [NSYM];
    logic [LEN_W-1:0]  len_tbl  [NSYM];

    // Codes are stored masked so stray bits above the code length never reach the accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSYM; i++) begin
                code_tbl[i] <= '0;
                len_tbl[i]  <= '0;
            end
        end else if (code_valid) begin
            for (int i = 0; i < NSYM; i++) begin
                code_tbl[i] <= hc[i] & mask[i];
                len_tbl[i]  <= LEN_W'(popcount(32'(mask[i])));
            end
        end
    end

    always_comb begin
        code    = '0;
        len     = '0;
        illegal = 1'b1;
        for (int i = 0; i < NSYM; i++) begin
            if (sym == 8'(i + 1)) begin
                code    = code_tbl[i];
                len     = len_tbl[i];
                illegal = (len_tbl[i] == '0);
            end
        end
    end

endmodule

// File: rtl/huffman_packer.sv
// Maps gray symbols to Huffman codes and packs them MSB-first into a valid/ready byte stream.
module huffman_packer
    import huffman_pkg::*;
#(
    parameter int CODE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              sym_valid,
    input  logic [7:0]        sym_data,
    input  logic              sym_last,
    output logic              sym_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sym_err
);

    localparam int ACC_W = 2 * CODE_W;
    localparam int LEN_W = $clog2(CODE_W + 1);
    localparam int CNT_W = $clog2(ACC_W + 1);

    logic [CODE_W-1:0] hc   [NSYM];
    logic [CODE_W-1:0] mask [NSYM];
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
    logic              illegal;

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  shift;
    logic              accept, slot_free, last_pending, emit_full, emit_tail;

    assign hc   = '{HC1, HC2, HC3, HC4, HC5, HC6};
    assign mask = '{M1, M2, M3, M4, M5, M6};

    huffman_code_lut #(.CODE_W(CODE_W)) u_lut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .hc         (hc),
        .mask       (mask),
        .sym        (sym_data),
        .code       (code),
        .len        (len),
        .illegal    (illegal)
    );

    assign sym_ready    = (state == RUN) && (bit_cnt < CNT_W'(BYTE_W));
    assign accept       = sym_valid && sym_ready;
    assign slot_free    = !out_valid || out_ready;
    assign last_pending = out_valid && out_last;
    assign emit_full    = (bit_cnt >= CNT_W'(BYTE_W)) && slot_free;
    // The tail byte also covers a frame that ends with nothing pending: it goes out as 0x00.
    assign emit_tail    = (state == FLUSH) && (bit_cnt < CNT_W'(BYTE_W)) && slot_free && !last_pending;
    assign shift        = CNT_W'(ACC_W) - bit_cnt - CNT_W'(len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (code_valid) state_next = RUN;
            RUN:     if (accept && sym_last) state_next = FLUSH;
            FLUSH:   if (last_pending && out_ready) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Appends and byte moves are mutually exclusive because intake requires fewer than 8 bits held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            bit_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sym_err   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (illegal) begin
                    sym_err <= 1'b1;
                end else begin
                    acc     <= acc | (ACC_W'(code) << shift);
                    bit_cnt <= bit_cnt + CNT_W'(len);
                end
            end else if (emit_full) begin
                out_valid <= 1'b1;
                out_data  <= acc[ACC_W-1 -: BYTE_W];
                out_last  <= (state == FLUSH) && (bit_cnt == CNT_W'(BYTE_W));
                acc       <= acc << BYTE_W;
                bit_cnt   <= bit_cnt - CNT_W'(BYTE_W);
            end else if (emit_tail) begin
                out_valid <= 1'b1;
                out_data  <= acc[ACC_W-1 -: BYTE_W];
                out_last  <= 1'b1;
                acc       <= '0;
                bit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer: table-driven frames plus stall and reset sequences.
module tb_huffman_packer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0] M1, M2, M3, M4, M5, M6;
    logic       sym_valid = 1'b0;
    logic [7:0] sym_data = 8'd0;
    logic       sym_last = 1'b0;
    logic       sym_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       sym_err;

    int         total = 0;
    int         bad = 0;
    logic       err_exp = 1'b0;
    logic [7:0] cap_data [8];
    logic       cap_last [8];
    int         cap_n;

    typedef struct {
        int               nsym;
        logic [0:7][7:0]  syms;
        int               nbytes;
        logic [0:3][7:0]  bytes;
        logic             err;
    } frame_t;

    frame_t frames [6];

    huffman_packer #(.CODE_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1 (HC1), .HC2 (HC2), .HC3 (HC3), .HC4 (HC4), .HC5 (HC5), .HC6 (HC6),
        .M1  (M1),  .M2  (M2),  .M3  (M3),  .M4  (M4),  .M5  (M5),  .M6  (M6),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .sym_err    (sym_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Called at a negedge; returns at the negedge after the symbol is accepted.
    task automatic send_sym(input logic [7:0] s, input logic l);
        int n;
        n = 0;
        sym_valid = 1'b1;
        sym_data  = s;
        sym_last  = l;
        while (!sym_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) report_timeout("send_sym");
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic collect_bytes(input int cycles);
        cap_n = 0;
        for (int c = 0; c < cycles; c++) begin
            if (out_valid && out_ready && cap_n < 8) begin
                cap_data[cap_n] = out_data;
                cap_last[cap_n] = out_last;
                cap_n++;
            end
            @(negedge clk);
        end
    endtask

    // Feeds one frame while draining bytes and checking each against the table.
    task automatic apply_stimulus(input int fi, input frame_t f);
        int   idx, nb, cyc;
        logic done, acc_now;
        idx  = 0;
        nb   = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            sym_valid = (idx < f.nsym);
            sym_data  = (idx < f.nsym) ? f.syms[idx] : 8'd0;
            sym_last  = (idx == f.nsym - 1);
            acc_now   = sym_valid && sym_ready;
            if (out_valid && out_ready) begin
                if (nb < f.nbytes) begin
                    check_output($sformatf("f%0d_data%0d", fi, nb), 16'(out_data), 16'(f.bytes[nb]));
                    check_output($sformatf("f%0d_last%0d", fi, nb), 16'(out_last), 16'(nb == f.nbytes - 1));
                end else begin
                    check_output($sformatf("f%0d_extra_byte", fi), 16'(nb), 16'(f.nbytes - 1));
                end
                if (out_last) done = 1'b1;
                nb++;
            end
            @(posedge clk);
            if (acc_now) idx++;
            @(negedge clk);
            cyc++;
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        if (!done) report_timeout($sformatf("f%0d_frame", fi));
        err_exp = err_exp | f.err;
        check_output($sformatf("f%0d_nbytes", fi), 16'(nb), 16'(f.nbytes));
        check_output($sformatf("f%0d_sym_err", fi), 16'(sym_err), 16'(err_exp));
        check_output($sformatf("f%0d_ready_run", fi), 16'(sym_ready), 16'd1);
        @(negedge clk);
        check_output($sformatf("f%0d_idle_out", fi), 16'(out_valid), 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation ran too long");
        $fatal(1);
    end

    initial begin
        HC1 = 8'h00; HC2 = 8'h02; HC3 = 8'h06; HC4 = 8'h0E; HC5 = 8'h1E; HC6 = 8'h1F;
        M1  = 8'h01; M2  = 8'h03; M3  = 8'h07; M4  = 8'h0F; M5  = 8'h1F; M6  = 8'h1F;

        frames[0] = '{4, {8'd1, 8'd2, 8'd3, 8'd4, 32'd0}, 2, {8'h5B, 8'h80, 16'h0}, 1'b0};
        frames[1] = '{2, {8'd6, 8'd6, 48'd0},             2, {8'hFF, 8'hC0, 16'h0}, 1'b0};
        frames[2] = '{8, {8{8'd1}},                       1, {8'h00, 24'h0},        1'b0};
        frames[3] = '{3, {8'd5, 8'd3, 8'd1, 40'd0},       2, {8'hF6, 8'h00, 16'h0}, 1'b0};
        frames[4] = '{2, {8'd4, 8'd4, 48'd0},             1, {8'hEE, 24'h0},        1'b0};
        frames[5] = '{3, {8'd0, 8'd7, 8'd2, 40'd0},       1, {8'h80, 24'h0},        1'b1};

        #3;
        check_output("rst_out_valid", 16'(out_valid), 16'd0);
        check_output("rst_out_data",  16'(out_data),  16'd0);
        check_output("rst_out_last",  16'(out_last),  16'd0);
        check_output("rst_sym_ready", 16'(sym_ready), 16'd0);
        check_output("rst_sym_err",   16'(sym_err),   16'd0);

        @(negedge clk);
        reset = 1'b1;
        sym_valid = 1'b1;
        sym_data  = 8'd1;
        repeat (2) @(negedge clk);
        check_output("idle_no_table", 16'(sym_ready), 16'd0);
        sym_valid  = 1'b0;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        check_output("table_loaded", 16'(sym_ready), 16'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(i, frames[i]);
        end

        // Back-pressure: the first byte is held and intake stops at 12 pending bits.
        $display("[TB] stall sequence");
        out_ready = 1'b0;
        repeat (4) send_sym(8'd6, 1'b0);
        check_output("stall_valid", 16'(out_valid), 16'd1);
        check_output("stall_data",  16'(out_data),  16'h00FF);
        check_output("stall_ready", 16'(sym_ready), 16'd0);
        repeat (3) @(negedge clk);
        check_output("hold_data",  16'(out_data),  16'h00FF);
        check_output("hold_valid", 16'(out_valid), 16'd1);
        check_output("hold_ready", 16'(sym_ready), 16'd0);
        out_ready = 1'b1;
        collect_bytes(6);
        check_output("drain_count", 16'(cap_n), 16'd2);
        check_output("drain_b0", 16'(cap_data[0]), 16'h00FF);
        check_output("drain_b1", 16'(cap_data[1]), 16'h00FF);
        check_output("drain_l1", 16'(cap_last[1]), 16'd0);
        check_output("drain_ready", 16'(sym_ready), 16'd1);
        send_sym(8'd1, 1'b1);
        collect_bytes(6);
        check_output("tail_count", 16'(cap_n), 16'd1);
        check_output("tail_data",  16'(cap_data[0]), 16'h00F0);
        check_output("tail_last",  16'(cap_last[0]), 16'd1);
        check_output("tail_ready", 16'(sym_ready), 16'd1);

        // Asynchronous reset while a byte is waiting on the output.
        $display("[TB] reset sequence");
        out_ready = 1'b0;
        send_sym(8'd6, 1'b0);
        send_sym(8'd6, 1'b0);
        repeat (2) @(negedge clk);
        check_output("pre_rst_valid", 16'(out_valid), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("arst_out_valid", 16'(out_valid), 16'd0);
        check_output("arst_out_data",  16'(out_data),  16'd0);
        check_output("arst_out_last",  16'(out_last),  16'd0);
        check_output("arst_sym_ready", 16'(sym_ready), 16'd0);
        check_output("arst_sym_err",   16'(sym_err),   16'd0);
        @(negedge clk);
        reset = 1'b1;
        sym_valid = 1'b1;
        sym_data  = 8'd2;
        repeat (3) @(negedge clk);
        check_output("post_rst_ready", 16'(sym_ready), 16'd0);
        sym_valid  = 1'b0;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        check_output("reload_ready", 16'(sym_ready), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
